// File: rtl/qu_common_pkg.sv
// qu_common: shared definitions for the instruction-decode stage.
//   - optype_e   : operation class carried with every decoded packet
//   - qu_dec_t   : decoded-instruction packet (everything except the PC)
//   - imm_*      : one immediate-extraction function per RV32I format
//   - qu_decode  : the complete combinational decode of one instruction
//   - enc_*      : instruction encoders, the exact inverse of qu_decode for
//                  every encodable instruction
package qu_common;

  localparam int QU_PC_WIDTH    = 12;
  localparam int QU_INSTR_WIDTH = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    OT_ALU_R   = 4'd0,
    OT_ALU_I   = 4'd1,
    OT_LOAD    = 4'd2,
    OT_STORE   = 4'd3,
    OT_BRANCH  = 4'd4,
    OT_JAL     = 4'd5,
    OT_JALR    = 4'd6,
    OT_LUI     = 4'd7,
    OT_AUIPC   = 4'd8,
    OT_SYSTEM  = 4'd9,
    OT_CSR     = 4'd10,
    OT_FENCE   = 4'd11,
    OT_ILLEGAL = 4'd15
  } optype_e;

  typedef struct packed {
    optype_e     optype;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_valid;
    logic        rs1_valid;
    logic        rs2_valid;
    logic        imm_valid;
    logic [31:0] imm;
    logic        illegal;
  } qu_dec_t;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_csr(input logic [31:0] i);
    return {20'b0, i[31:20]};
  endfunction

  function automatic qu_dec_t qu_decode(input logic [31:0] i);
    qu_dec_t     d;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rdw;
    logic        r1;
    logic        r2;
    logic        iv;
    logic        ill;
    optype_e     op;
    logic [31:0] imm;
    opc = i[6:0];
    f3  = i[14:12];
    f7  = i[31:25];
    rdw = 1'b0;
    r1  = 1'b0;
    r2  = 1'b0;
    iv  = 1'b0;
    ill = 1'b0;
    op  = OT_ILLEGAL;
    imm = '0;
    // opc includes i[1:0], so compressed encodings fall into default
    case (opc)
      OPC_OP: begin
        op  = OT_ALU_R;
        rdw = 1'b1; r1 = 1'b1; r2 = 1'b1;
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        op  = OT_ALU_I;
        rdw = 1'b1; r1 = 1'b1; iv = 1'b1;
        imm = imm_i(i);
        if (f3 == 3'b001)      ill = (f7 != 7'h00);
        else if (f3 == 3'b101) ill = !((f7 == 7'h00) || (f7 == 7'h20));
      end
      OPC_LOAD: begin
        op  = OT_LOAD;
        rdw = 1'b1; r1 = 1'b1; iv = 1'b1;
        imm = imm_i(i);
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        op  = OT_STORE;
        r1  = 1'b1; r2 = 1'b1; iv = 1'b1;
        imm = imm_s(i);
        ill = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        op  = OT_BRANCH;
        r1  = 1'b1; r2 = 1'b1; iv = 1'b1;
        imm = imm_b(i);
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        op  = OT_JAL;
        rdw = 1'b1; iv = 1'b1;
        imm = imm_j(i);
      end
      OPC_JALR: begin
        op  = OT_JALR;
        rdw = 1'b1; r1 = 1'b1; iv = 1'b1;
        imm = imm_i(i);
        ill = (f3 != 3'b000);
      end
      OPC_LUI: begin
        op  = OT_LUI;
        rdw = 1'b1; iv = 1'b1;
        imm = imm_u(i);
      end
      OPC_AUIPC: begin
        op  = OT_AUIPC;
        rdw = 1'b1; iv = 1'b1;
        imm = imm_u(i);
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          // ECALL / EBREAK: the I-immediate selects which one
          op  = OT_SYSTEM;
          iv  = 1'b1;
          imm = imm_i(i);
          ill = (i[31:20] > 12'd1);
        end else if (f3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          // CSRRxI variants reuse the rs1 slot as a 5-bit immediate
          op  = OT_CSR;
          rdw = 1'b1; r1 = !f3[2]; iv = 1'b1;
          imm = imm_csr(i);
        end
      end
      OPC_FENCE: begin
        op  = OT_FENCE;
        ill = (f3 >= 3'b010);
      end
      default: ill = 1'b1;
    endcase
    d        = '0;
    d.funct3 = f3;
    d.funct7 = f7;
    d.rd     = i[11:7];
    d.rs1    = i[19:15];
    d.rs2    = i[24:20];
    if (ill) begin
      d.optype  = OT_ILLEGAL;
      d.illegal = 1'b1;
    end else begin
      d.optype    = op;
      d.rd_valid  = rdw && (i[11:7] != 5'd0);
      d.rs1_valid = r1;
      d.rs2_valid = r2;
      d.imm_valid = iv;
      d.imm       = imm;
    end
    return d;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/qu_decoder_if.sv
// qu_decoder_if: fetch-side and dispatch-side handshake bundle of the decoder.
//   in_*  : instruction + PC from fetch (valid/ready)
//   out_* : decoded packet towards rename/dispatch (valid/ready)
// Modports: master = fetch/consumer side (bench), slave = decoder.
interface qu_decoder_if #(
  parameter int PC_WIDTH = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [3:0]          out_optype;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic                out_rd_valid;
  logic                out_rs1_valid;
  logic                out_rs2_valid;
  logic                out_imm_valid;
  logic [31:0]         out_imm;
  logic                out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_optype, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_rd_valid, out_rs1_valid, out_rs2_valid,
           out_imm_valid, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_optype, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_rd_valid, out_rs1_valid, out_rs2_valid,
           out_imm_valid, out_imm, out_illegal
  );
endinterface

// File: rtl/qu_decoder.sv
// qu_decoder: registered RV32I decode stage with a 2-entry skid buffer.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset, clears both buffer entries
//   flush - drops everything buffered and anything offered this cycle
//   bus   - qu_decoder_if.slave: in_* from fetch, out_* to dispatch
// Decode happens before the register, so out_* come straight from flops
// and in_ready is a flop output (not skid-full).
module qu_decoder
  import qu_common::*;
#(
  parameter int PC_WIDTH    = QU_PC_WIDTH,
  parameter int INSTR_WIDTH = QU_INSTR_WIDTH
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  qu_decoder_if.slave bus
);

  logic [INSTR_WIDTH-1:0] instr_w;
  qu_dec_t                dec_in;
  logic                   accept;

  logic                main_vld_q, main_vld_d;
  qu_dec_t             main_q,     main_d;
  logic [PC_WIDTH-1:0] main_pc_q,  main_pc_d;
  logic                skid_vld_q, skid_vld_d;
  qu_dec_t             skid_q,     skid_d;
  logic [PC_WIDTH-1:0] skid_pc_q,  skid_pc_d;

  assign instr_w = bus.in_instr;

  always_comb begin
    dec_in     = qu_decode(instr_w);
    accept     = bus.in_valid && !skid_vld_q && !flush;
    main_vld_d = main_vld_q;
    main_d     = main_q;
    main_pc_d  = main_pc_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || bus.out_ready) begin
      // main is free this edge: the older skid packet has priority,
      // and in_ready is low whenever skid is occupied
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        main_pc_d  = skid_pc_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_d    = dec_in;
          main_pc_d = bus.in_pc;
        end
      end
    end else if (accept) begin
      // main stalled: park the new packet in skid
      skid_vld_d = 1'b1;
      skid_d     = dec_in;
      skid_pc_d  = bus.in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      main_pc_q  <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      main_pc_q  <= main_pc_d;
    end
  end

  // skid contents are only observed through skid_vld_q, so no reset needed
  always_ff @(posedge clk) begin
    skid_q    <= skid_d;
    skid_pc_q <= skid_pc_d;
  end

  assign bus.in_ready      = !skid_vld_q;
  assign bus.out_valid     = main_vld_q;
  assign bus.out_pc        = main_pc_q;
  assign bus.out_optype    = main_q.optype;
  assign bus.out_funct3    = main_q.funct3;
  assign bus.out_funct7    = main_q.funct7;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_rs1       = main_q.rs1;
  assign bus.out_rs2       = main_q.rs2;
  assign bus.out_rd_valid  = main_q.rd_valid;
  assign bus.out_rs1_valid = main_q.rs1_valid;
  assign bus.out_rs2_valid = main_q.rs2_valid;
  assign bus.out_imm_valid = main_q.imm_valid;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_qu_decoder.sv
// tb_qu_decoder: table-driven bench for qu_decoder plus hand-written
// backpressure, flush, async-reset and encode/decode round-trip sequences.
module tb_qu_decoder;
  import qu_common::*;

  logic clk;
  logic rst;
  logic flush;
  int   n_vec;
  int   n_err;

  qu_decoder_if #(.PC_WIDTH(12)) bus ();

  qu_decoder #(.PC_WIDTH(12), .INSTR_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  vld;   // {rd_valid, rs1_valid, rs2_valid, imm_valid}
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_addi(input int n);
    return {12'(n), 5'd0, 3'd0, 5'(n), 7'h13};
  endfunction

  initial begin
    logic [2:0]  i_f3s [6];
    logic [2:0]  b_f3s [6];
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] im12;
    logic [12:0] im13;
    logic [19:0] im20;
    logic [20:0] im21;
    logic [31:0] ins, eimm;
    logic [3:0]  eop;
    logic        has_rd, has_rs2;
    logic [63:0] act_p, exp_p;
    int          t;

    i_f3s = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    b_f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    n_vec = 0;
    n_err = 0;

    //           instr          op     rd     rs1     rs2     f3    f7     vld      imm           ill
    vt[0]  = '{32'h002081B3, 4'd0,  5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 4'b1110, 32'h00000000, 1'b0}; // ADD x3,x1,x2
    vt[1]  = '{32'hFFF00293, 4'd1,  5'd5,  5'd0,  5'd31, 3'd0, 7'h7F, 4'b1101, 32'hFFFFFFFF, 1'b0}; // ADDI x5,x0,-1
    vt[2]  = '{32'hFE000EE3, 4'd4,  5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 4'b0111, 32'hFFFFFFFC, 1'b0}; // BEQ -4
    vt[3]  = '{32'h00000000, 4'd15, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 4'b0000, 32'h00000000, 1'b1}; // all-zero
    vt[4]  = '{32'h0020A1B3, 4'd0,  5'd3,  5'd1,  5'd2,  3'd2, 7'h00, 4'b1110, 32'h00000000, 1'b0}; // SLT
    vt[5]  = '{32'h4020A1B3, 4'd15, 5'd3,  5'd1,  5'd2,  3'd2, 7'h20, 4'b0000, 32'h00000000, 1'b1}; // bad funct7
    vt[6]  = '{32'h123453B7, 4'd7,  5'd7,  5'd8,  5'd3,  3'd5, 7'h09, 4'b1001, 32'h12345000, 1'b0}; // LUI
    vt[7]  = '{32'h00512423, 4'd3,  5'd8,  5'd2,  5'd5,  3'd2, 7'h00, 4'b0111, 32'h00000008, 1'b0}; // SW x5,8(x2)
    vt[8]  = '{32'hFF9FF0EF, 4'd5,  5'd1,  5'd31, 5'd25, 3'd7, 7'h7F, 4'b1001, 32'hFFFFFFF8, 1'b0}; // JAL x1,-8
    vt[9]  = '{32'h00013083, 4'd15, 5'd1,  5'd2,  5'd0,  3'd3, 7'h00, 4'b0000, 32'h00000000, 1'b1}; // LOAD f3=011
    vt[10] = '{32'h305110F3, 4'd10, 5'd1,  5'd2,  5'd5,  3'd1, 7'h18, 4'b1101, 32'h00000305, 1'b0}; // CSRRW
    vt[11] = '{32'h40315093, 4'd1,  5'd1,  5'd2,  5'd3,  3'd5, 7'h20, 4'b1101, 32'h00000403, 1'b0}; // SRAI
    vt[12] = '{32'h00000073, 4'd9,  5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 4'b0001, 32'h00000000, 1'b0}; // ECALL
    vt[13] = '{32'h00200073, 4'd15, 5'd0,  5'd0,  5'd2,  3'd0, 7'h00, 4'b0000, 32'h00000000, 1'b1}; // SYSTEM imm=2
    vt[14] = '{32'h00208033, 4'd0,  5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 4'b0110, 32'h00000000, 1'b0}; // ADD x0
    vt[15] = '{32'h0FF0000F, 4'd11, 5'd0,  5'd0,  5'd31, 3'd0, 7'h07, 4'b0000, 32'h00000000, 1'b0}; // FENCE

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst.data", {bus.out_imm, 4'(bus.out_optype), bus.out_rd, bus.out_rs1, bus.out_rs2, 12'(bus.out_pc)},
        64'd0);
    rst = 1'b0;

    // ---------------- table vectors, out_ready held high ----------------
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_instr = vt[k].instr;
      bus.in_pc    = 12'(16 * k + 4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d.valid", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d.pc", k), 64'(bus.out_pc), 64'(16 * k + 4));
      chk($sformatf("v%0d.optype", k), 64'(bus.out_optype), 64'(vt[k].op));
      chk($sformatf("v%0d.illegal", k), 64'(bus.out_illegal), 64'(vt[k].ill));
      chk($sformatf("v%0d.regs", k), {bus.out_rd, bus.out_rs1, bus.out_rs2},
          {vt[k].rd, vt[k].rs1, vt[k].rs2});
      chk($sformatf("v%0d.funct", k), {bus.out_funct3, bus.out_funct7}, {vt[k].f3, vt[k].f7});
      chk($sformatf("v%0d.fvalid", k),
          {bus.out_rd_valid, bus.out_rs1_valid, bus.out_rs2_valid, bus.out_imm_valid}, 64'(vt[k].vld));
      chk($sformatf("v%0d.imm", k), 64'(bus.out_imm), 64'(vt[k].imm));
    end

    // ---------------- backpressure: fill main + skid ----------------
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk_addi(1);
    @(negedge clk);
    chk("bp.ready_c2", 64'(bus.in_ready), 64'd1);
    bus.in_instr = mk_addi(2);
    @(negedge clk);
    chk("bp.ready_c3", 64'(bus.in_ready), 64'd0);
    chk("bp.first_rd", 64'(bus.out_rd), 64'd1);
    bus.in_instr = mk_addi(3);
    @(negedge clk);
    chk("bp.ready_held", 64'(bus.in_ready), 64'd0);
    chk("bp.stable", {bus.out_valid, bus.out_rd, bus.out_imm}, {1'b1, 5'd1, 32'd1});
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.second", {bus.out_valid, bus.out_rd, bus.out_imm}, {1'b1, 5'd2, 32'd2});
    chk("bp.ready_after_drain", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.third", {bus.out_valid, bus.out_rd, bus.out_imm}, {1'b1, 5'd3, 32'd3});
    @(negedge clk);
    chk("bp.empty", 64'(bus.out_valid), 64'd0);

    // ---------------- flush with main + skid full and input offered ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk_addi(4);
    @(negedge clk);
    bus.in_instr = mk_addi(5);
    @(negedge clk);
    chk("fl.full", {bus.out_valid, bus.in_ready}, {1'b1, 1'b0});
    bus.in_instr = mk_addi(6);
    flush        = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl.out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl.in_ready",  64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("fl.no_ghost%0d", c), 64'(bus.out_valid), 64'd0);
    end
    // flush while empty must drop the offered instruction
    bus.in_valid = 1'b1;
    bus.in_instr = mk_addi(7);
    flush        = 1'b1;
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl.drop_in", 64'(bus.out_valid), 64'd0);

    // ---------------- asynchronous reset mid-operation ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = mk_addi(8);
    @(negedge clk);
    bus.in_instr = mk_addi(9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ar.full", {bus.out_valid, bus.in_ready}, {1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("ar.cleared", {bus.out_valid, bus.in_ready, bus.out_rd}, {1'b0, 1'b1, 5'd0});
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ar.stays_empty", 64'(bus.out_valid), 64'd0);

    // ---------------- encode/decode round-trip ----------------
    for (int k = 0; k < 60; k++) begin
      t       = int'($urandom_range(0, 5));
      rd      = 5'($urandom_range(1, 31));
      rs1     = 5'($urandom);
      rs2     = 5'($urandom);
      has_rd  = 1'b1;
      has_rs2 = 1'b0;
      case (t)
        0: begin
          f3   = 3'($urandom);
          f7   = (((f3 == 3'd0) || (f3 == 3'd5)) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          ins  = enc_r(f7, rs2, rs1, f3, rd, OPC_OP);
          eop  = 4'd0; eimm = 32'd0; has_rs2 = 1'b1;
        end
        1: begin
          im12 = 12'($urandom);
          ins  = enc_i(im12, rs1, i_f3s[$urandom_range(0, 5)], rd, OPC_OPIMM);
          eop  = 4'd1; eimm = {{20{im12[11]}}, im12};
        end
        2: begin
          im12 = 12'($urandom);
          ins  = enc_s(im12, rs2, rs1, 3'($urandom_range(0, 2)), OPC_STORE);
          eop  = 4'd3; eimm = {{20{im12[11]}}, im12}; has_rd = 1'b0; has_rs2 = 1'b1;
        end
        3: begin
          im13 = {12'($urandom), 1'b0};
          ins  = enc_b(im13, rs2, rs1, b_f3s[$urandom_range(0, 5)], OPC_BRANCH);
          eop  = 4'd4; eimm = {{19{im13[12]}}, im13}; has_rd = 1'b0; has_rs2 = 1'b1;
        end
        4: begin
          im20 = 20'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            ins = enc_u(im20, rd, OPC_LUI);   eop = 4'd7;
          end else begin
            ins = enc_u(im20, rd, OPC_AUIPC); eop = 4'd8;
          end
          eimm = {im20, 12'd0};
        end
        default: begin
          im21 = {20'($urandom), 1'b0};
          ins  = enc_j(im21, rd, OPC_JAL);
          eop  = 4'd5; eimm = {{11{im21[20]}}, im21};
        end
      endcase
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      bus.in_pc    = 12'(k);
      @(negedge clk);
      bus.in_valid = 1'b0;
      exp_p = {7'd0, 1'b1, eop, has_rd ? rd : 5'd0,
               (t == 4 || t == 5) ? 5'd0 : rs1, has_rs2 ? rs2 : 5'd0, eimm, 1'b0};
      act_p = {7'd0, bus.out_valid, bus.out_optype, has_rd ? bus.out_rd : 5'd0,
               (t == 4 || t == 5) ? 5'd0 : bus.out_rs1, has_rs2 ? bus.out_rs2 : 5'd0,
               bus.out_imm, bus.out_illegal};
      chk($sformatf("rt%0d(instr=0x%08h)", k, ins), act_p, exp_p);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qu_decoder.md
Name: qu_decoder

Overview:
- Registered instruction-decode stage between fetch and rename/reservation-station dispatch.
- Accepts one 32-bit RV32I instruction plus PC per cycle over valid/ready.
- Splits each instruction into register fields, a sign-extended 32-bit immediate, an operation class and legality flags.
- Inverse of the shared instruction-encoding helpers: for every encodable instruction, decoding its encoding returns the same fields.
- 2-entry skid buffer so in_ready is a register output.

Parameters:
- PC_WIDTH, QU_PC_WIDTH (12), PC width.
- INSTR_WIDTH, QU_INSTR_WIDTH (32), instruction width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all buffered and incoming instructions
- in_valid  in  1  instruction/PC valid
- in_ready  out  1  decoder can accept
- in_instr  in  32  raw instruction
- in_pc  in  PC_WIDTH  instruction address
- out_valid  out  1  decoded packet valid
- out_ready  in  1  consumer accepts
- out_pc  out  PC_WIDTH  PC of decoded instruction
- out_optype  out  4  operation class (package enum)
- out_funct3  out  3  funct3 field
- out_funct7  out  7  funct7 field
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses
- out_rd_valid / out_rs1_valid / out_rs2_valid / out_imm_valid  out  1 each  field used by this instruction
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  instruction not legal RV32I

Behaviour:
- Reset: out_valid=0, all out_* data=0, in_ready=1, skid buffer empty.
- Handshake and latency:
  - Input is accepted when in_valid and in_ready are both high.
  - Output transfers when out_valid and out_ready are both high.
  - Latency is 1 cycle: an instruction accepted on edge N is presented on out_* after edge N.
- Skid buffer (main register + skid register):
  - If main holds a stalled packet (out_valid and !out_ready) and an input is accepted, the new packet goes to skid.
  - in_ready is driven as !skid_valid.
  - When main drains, skid moves to main.
  - Order is always preserved and there are no bubbles at full throughput.
  - Data on out_* is stable while out_valid and !out_ready.
- Flush:
  - Next cycle: out_valid=0 and skid empty.
  - An input presented in the same cycle as flush is dropped.
  - flush overrides acceptance.
- Optype enum: ALU_R=0, ALU_I=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, SYSTEM=9, CSR=10, FENCE=11, ILLEGAL=15.
- Immediates:
  - I-type: sext(i[31:20]).
  - S-type: sext({i[31:25], i[11:7]}).
  - B-type: sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - J-type: sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - U-type: {i[31:12], 12'b0}.
  - CSR: zero-extended csr field.
  - R-type and FENCE: out_imm_valid=0.
- Field validity:
  - rd_valid=1 only when the format writes rd and rd!=0.
  - rs1_valid for R/I/LOAD/S/B/JALR/CSRRW/CSRRS/CSRRC.
  - rs2_valid for R/S/B.
- Legality (out_illegal=1 and optype=ILLEGAL):
  - Unknown opcode, including i[1:0]!=2'b11.
  - R-type with funct7 not 0000000; 0100000 is legal only for funct3 000/101.
  - SLLI with i[31:25]!=0.
  - SRLI/SRAI with i[31:25] not 0000000/0100000.
  - LOAD funct3 011/110/111.
  - STORE funct3 >= 011.
  - BRANCH funct3 010/011.
  - JALR funct3!=000.
  - SYSTEM funct3=000 with imm not 0/1, or funct3=100.
  - FENCE funct3 >= 010.
- Illegal packets still flow through the handshake normally; exception handling happens downstream.
- rst asserted mid-operation clears both buffers immediately, without waiting for a clock edge.

Decomposition:
- Optype enum, a decoded-instruction packed struct and the immediate-extraction functions (one per format) go into qu_common.
- The combinational decode is a function in qu_common so the bench scoreboard reuses it.
- No sub-module: the skid buffer is inline.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) -> one cycle later: optype 0, rd=3, rs1=1, rs2=2, rd/rs1/rs2_valid=1, imm_valid=0, illegal=0.
- 0xFFF00293 (ADDI x5,x0,-1) -> optype 1, rd=5, imm=0xFFFFFFFF, rs2_valid=0.
- 0xFE000EE3 (BEQ x0,x0,-4) -> optype 4, imm=0xFFFFFFFC, rd_valid=0, funct3=000.
- 0x00000000 and 0x0020A1B3 (funct7=0000000 but encoding SLT fine) vs 0x4020A1B3 (funct7=0100000, funct3=010) -> first and third illegal=1, optype 15; second legal.
- out_ready=0, push three instructions back-to-back -> two accepted, in_ready=0 on cycle 3. Then out_ready=1 -> outputs in order, third accepted once skid drains.
- Flush while main and skid are both full and in_valid=1 -> next cycle out_valid=0, in_ready=1, none of the three packets ever appears. Random encode/decode round-trip over all encoder helpers -> zero scoreboard mismatches.
